// File: rtl/ids_dma_pkg.sv
// ids_dma_pkg
//   Shared types and constants for the DMA requester-side bus engine.
//   - dma_mst_state_t : bus master FSM state encoding
//   - DMA_*_DEF       : default parameter widths
//   - DMA_WORD_BYTES  : byte step between consecutive words at default width
//   - dma_word_bytes  : byte step for an arbitrary bus word width
package ids_dma_pkg;

  localparam int DMA_ADDR_W_DEF = 32;
  localparam int DMA_DATA_W_DEF = 32;
  localparam int DMA_LEN_W_DEF  = 16;
  localparam int DMA_TMO_W_DEF  = 8;

  function automatic int dma_word_bytes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DMA_WORD_BYTES = dma_word_bytes(DMA_DATA_W_DEF);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    FIN     = 3'd4
  } dma_mst_state_t;

endpackage

// File: rtl/ids_dma_gnt_watchdog.sv
// ids_dma_gnt_watchdog
//   Counts consecutive cycles the engine waits for a bus grant. Expires on
//   the waiting cycle in which the count reaches 2^TMO_W-1.
//   Only instantiated when IDS_DMA_TIMEOUT_EN is defined.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : engine is waiting for the grant this cycle
//   i_clear      : grant seen or engine not waiting; restart the count
//   o_expire     : wait limit reached this cycle
module ids_dma_gnt_watchdog
  import ids_dma_pkg::*;
#(
  parameter int TMO_W = DMA_TMO_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expire
);

  // Terminal compare one below all-ones: the cycle that would make the
  // count reach 2^TMO_W-1 is the expiring cycle.
  localparam logic [TMO_W-1:0] CNT_TC = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_en && (cnt != CNT_TC)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign o_expire = i_en && !i_clear && (cnt == CNT_TC);

endmodule

// File: rtl/ids_dma_bus_master.sv
// ids_dma_bus_master
//   Requester-side DMA bus engine. Accepts a word-copy command, requests the
//   shared bus and moves one word at a time (read source, then write
//   destination), issuing accesses only in cycles where the grant is high.
//   Grant loss stalls the current beat, which is reissued when the grant
//   returns.
//   Optional feature macro: IDS_DMA_TIMEOUT_EN (grant-wait timeout with
//   abort and o_err pulse). Without it o_err is tied low and the engine
//   waits for the grant indefinitely.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready    : command handshake (ready only in IDLE)
//   i_cmd_src, i_cmd_dst         : word-aligned byte addresses
//   i_cmd_len                    : number of words to copy
//   o_busy, o_done, o_err        : status, done/abort one-cycle pulses
//   o_req_dma / i_gnt_dma        : arbiter request / registered grant
//   o_bus_valid, o_bus_we        : access issued, write enable
//   o_bus_addr, o_bus_wdata      : access address, write data
//   i_bus_rdata                  : read data, one cycle after a read issues
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | ready for a command
//   RD      | requesting bus, read of src issues when granted
//   RD_WAIT | read data returning, captured into the word buffer
//   WR      | requesting bus, write of dst issues when granted
//   FIN     | done (and err on abort) pulse, request dropped
module ids_dma_bus_master
  import ids_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W_DEF,
  parameter int DATA_W = DMA_DATA_W_DEF,
  parameter int LEN_W  = DMA_LEN_W_DEF,
  parameter int TMO_W  = DMA_TMO_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_src,
  input  logic [ADDR_W-1:0] i_cmd_dst,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_req_dma,
  input  logic              i_gnt_dma,
  output logic              o_bus_valid,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(dma_word_bytes(DATA_W));
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  // The watchdog needs at least a 2-bit counter for its terminal compare.
  if (TMO_W < 2) begin : g_tmo_w_chk
    $error("ids_dma_bus_master: TMO_W must be at least 2");
  end

  dma_mst_state_t state, state_nxt;

  logic [ADDR_W-1:0] src_q, src_nxt;
  logic [ADDR_W-1:0] dst_q, dst_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [DATA_W-1:0] buf_q, buf_nxt;

  logic tmo_expire;
  logic abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      buf_q <= '0;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
      dst_q <= dst_nxt;
      len_q <= len_nxt;
      buf_q <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    src_nxt     = src_q;
    dst_nxt     = dst_q;
    len_nxt     = len_q;
    buf_nxt     = buf_q;
    abort       = 1'b0;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_req_dma   = 1'b0;
    o_bus_valid = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;

    case (state)
      IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (i_cmd_len == '0) begin
            state_nxt = FIN;
          end else begin
            src_nxt   = i_cmd_src;
            dst_nxt   = i_cmd_dst;
            len_nxt   = i_cmd_len;
            state_nxt = RD;
          end
        end
      end

      RD: begin
        o_req_dma  = 1'b1;
        o_bus_addr = src_q;
        if (i_gnt_dma) begin
          o_bus_valid = 1'b1;
          state_nxt   = RD_WAIT;
        end else if (tmo_expire) begin
          abort = 1'b1;
        end
      end

      RD_WAIT: begin
        // Data returns a fixed cycle after the read issued, so it is taken
        // even if the arbiter has pulled the grant meanwhile.
        o_req_dma = 1'b1;
        buf_nxt   = i_bus_rdata;
        state_nxt = WR;
      end

      WR: begin
        o_req_dma   = 1'b1;
        o_bus_we    = 1'b1;
        o_bus_addr  = dst_q;
        o_bus_wdata = buf_q;
        if (i_gnt_dma) begin
          o_bus_valid = 1'b1;
          src_nxt     = src_q + ADDR_STEP;
          dst_nxt     = dst_q + ADDR_STEP;
          len_nxt     = len_q - LEN_ONE;
          state_nxt   = (len_nxt == '0) ? FIN : RD;
        end else if (tmo_expire) begin
          abort = 1'b1;
        end
      end

      FIN: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (abort) begin
      state_nxt = FIN;
      len_nxt   = '0;
    end
  end

`ifdef IDS_DMA_TIMEOUT_EN
  logic tmo_wait;
  logic err_q;

  assign tmo_wait = ((state == RD) || (state == WR)) && !i_gnt_dma;

  ids_dma_gnt_watchdog #(
    .TMO_W (TMO_W)
  ) u_gnt_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (tmo_wait),
    .i_clear  (!tmo_wait),
    .o_expire (tmo_expire)
  );

  // Remembers that the coming FIN is an abort, so o_err lines up with o_done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end else if (state == FIN) begin
      err_q <= 1'b0;
    end
  end

  assign o_err = (state == FIN) && err_q;
`else
  assign tmo_expire = 1'b0;
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ids_dma_bus_master.sv
module tb_ids_dma_bus_master;
  import ids_dma_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int TMO_W  = 4;
  localparam int CYC_LIMIT = 60;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DMA_WORD_BYTES);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic              err;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              gnt_block;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_a_log[$];
  logic [DATA_W-1:0] wr_d_log[$];
  int                viol_log[$];

  always #5 clk = ~clk;

  ids_dma_bus_master #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LEN_W (LEN_W), .TMO_W (TMO_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_src   (cmd_src),
    .i_cmd_dst   (cmd_dst),
    .i_cmd_len   (cmd_len),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_req_dma   (req),
    .i_gnt_dma   (gnt),
    .o_bus_valid (bus_valid),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_rdata (bus_rdata)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Registered arbiter and memory: read data valid only the cycle after a read.
  always @(posedge clk) begin
    if (rst) gnt <= 1'b0;
    else     gnt <= req && !gnt_block;
    bus_rdata <= (bus_valid && !bus_we) ? mem_word(bus_addr) : 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (bus_valid) begin
      if (!gnt)        viol_log.push_back(1);
      else if (bus_we) begin wr_a_log.push_back(bus_addr); wr_d_log.push_back(bus_wdata); end
      else             rd_log.push_back(bus_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation time limit reached");
    $fatal(1, "tb timeout");
  end

  task automatic run_cmd(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [LEN_W-1:0] len, input logic [63:0] mask, input bit hold_valid,
                         output int done_cyc, output int err_cyc, output int req_high,
                         output int req_gaps, output int ready_busy);
    done_cyc = -1; err_cyc = -1; req_high = 0; req_gaps = 0; ready_busy = 0;
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (hold_valid) begin
      cmd_src = 32'hDEAD_0000; cmd_dst = 32'hBEEF_0000; cmd_len = 16'd7;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 1; k <= CYC_LIMIT && done_cyc < 0; k++) begin
      gnt_block = (k < 64) ? mask[k[5:0]] : 1'b0;
      @(negedge clk);
      if (req) req_high++;
      if (cmd_ready) ready_busy++;
      if (err && err_cyc < 0) err_cyc = k;
      if (done) done_cyc = k;
      else if (!req) req_gaps++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    gnt_block = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; gnt_block = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cmd_ready, busy, done, err} !== 4'b1000) begin
      fails++; $display("FAIL reset_status: got rdy/busy/done/err=%b required 1000", {cmd_ready, busy, done, err});
    end
    tests++;
    if ({req, bus_valid, bus_we} !== 3'b000) begin
      fails++; $display("FAIL reset_bus_ctl: got req/valid/we=%b required 000", {req, bus_valid, bus_we});
    end
    tests++;
    if (bus_addr !== '0 || bus_wdata !== '0) begin
      fails++; $display("FAIL reset_bus_data: got addr=%h wdata=%h required 0 0", bus_addr, bus_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_copy();
    int d, e, rh, rg, rb, r0, w0, v0;
    r0 = rd_log.size(); w0 = wr_a_log.size(); v0 = viol_log.size();
    run_cmd(32'h100, 32'h200, 16'd3, 64'd0, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (d !== 11) begin fails++; $display("FAIL basic_done_cycle: got %0d required 11", d); end
    tests++;
    if (rd_log.size() - r0 !== 3 || wr_a_log.size() - w0 !== 3) begin
      fails++; $display("FAIL basic_beats: got rd=%0d wr=%0d required 3 3", rd_log.size() - r0, wr_a_log.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rd_log[r0+i] !== 32'h100 + STEP * i || wr_a_log[w0+i] !== 32'h200 + STEP * i ||
            wr_d_log[w0+i] !== mem_word(32'h100 + STEP * i)) begin
          fails++;
          $display("FAIL basic_beat%0d: got rd=%h wr=%h data=%h required %h %h %h", i, rd_log[r0+i],
                   wr_a_log[w0+i], wr_d_log[w0+i], 32'h100 + STEP * i, 32'h200 + STEP * i, mem_word(32'h100 + STEP * i));
        end
      end
    end
    tests++;
    if (rg !== 0 || e !== -1 || viol_log.size() !== v0) begin
      fails++; $display("FAIL basic_req_err: got req_gaps=%0d err_cyc=%0d viol=%0d required 0 -1 0", rg, e, viol_log.size() - v0);
    end
  endtask

  task automatic test_len_zero();
    int d, e, rh, rg, rb, w0;
    w0 = wr_a_log.size();
    run_cmd(32'h100, 32'h200, 16'd0, 64'd0, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (d !== 1) begin fails++; $display("FAIL len0_done_cycle: got %0d required 1", d); end
    tests++;
    if (rh !== 0 || wr_a_log.size() !== w0) begin
      fails++; $display("FAIL len0_no_req: got req_cycles=%0d writes=%0d required 0 0", rh, wr_a_log.size() - w0);
    end
  endtask

  task automatic test_preempt();
    int d, e, rh, rg, rb, w0, v0;
    w0 = wr_a_log.size(); v0 = viol_log.size();
    // grant low in cycles 7..11: the WR of word 1
    run_cmd(32'h100, 32'h200, 16'd3, 64'h0000_0000_0000_07C0, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (d !== 16) begin fails++; $display("FAIL preempt_done_cycle: got %0d required 16", d); end
    tests++;
    if (viol_log.size() !== v0 || rg !== 0) begin
      fails++; $display("FAIL preempt_valid_req: got viol=%0d req_gaps=%0d required 0 0", viol_log.size() - v0, rg);
    end
    tests++;
    if (wr_a_log.size() - w0 !== 3) begin
      fails++; $display("FAIL preempt_writes: got %0d required 3", wr_a_log.size() - w0);
    end else begin
      tests++;
      if (wr_a_log[w0+1] !== 32'h204 || wr_d_log[w0+1] !== mem_word(32'h104) || wr_a_log[w0+2] !== 32'h208) begin
        fails++; $display("FAIL preempt_write_order: got %h/%h,%h required 204/%h,208", wr_a_log[w0+1], wr_d_log[w0+1],
                          wr_a_log[w0+2], mem_word(32'h104));
      end
    end
  endtask

  task automatic test_rdwait_drop();
    int d, e, rh, rg, rb, w0;
    w0 = wr_a_log.size();
    // grant low in cycles 3, 6, 9: every RD_WAIT
    run_cmd(32'h180, 32'h280, 16'd3, 64'h0000_0000_0000_0124, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (d !== 11) begin fails++; $display("FAIL rdwait_done_cycle: got %0d required 11", d); end
    tests++;
    if (wr_a_log.size() - w0 !== 3) begin
      fails++; $display("FAIL rdwait_writes: got %0d required 3", wr_a_log.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (wr_d_log[w0+i] !== mem_word(32'h180 + STEP * i)) begin
          fails++; $display("FAIL rdwait_data%0d: got %h required %h", i, wr_d_log[w0+i], mem_word(32'h180 + STEP * i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int d, e, rh, rg, rb, w0;
    w0 = wr_a_log.size();
    cmd_src = 32'h300; cmd_dst = 32'h400; cmd_len = 16'd4; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    tests++;
    if (wr_a_log.size() - w0 !== 1 || wr_a_log[w0] !== 32'h400) begin
      fails++; $display("FAIL rstmid_first_write: got count=%0d required 1 at 400", wr_a_log.size() - w0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({req, busy, cmd_ready, bus_valid} !== 4'b0010) begin
      fails++; $display("FAIL rstmid_idle: got req/busy/rdy/valid=%b required 0010", {req, busy, cmd_ready, bus_valid});
    end
    @(posedge clk); #1;
    w0 = wr_a_log.size();
    run_cmd(32'h500, 32'h600, 16'd2, 64'd0, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (d !== 8 || wr_a_log.size() - w0 !== 2) begin
      fails++; $display("FAIL rstmid_rerun: got done=%0d writes=%0d required 8 2", d, wr_a_log.size() - w0);
    end else begin
      tests++;
      if (wr_a_log[w0+1] !== 32'h604 || wr_d_log[w0+1] !== mem_word(32'h504)) begin
        fails++; $display("FAIL rstmid_rerun_data: got %h/%h required 604/%h", wr_a_log[w0+1], wr_d_log[w0+1], mem_word(32'h504));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int d, e, rh, rg, rb, w0;
    w0 = wr_a_log.size();
    run_cmd(32'h900, 32'hA00, 16'd2, 64'd0, 1'b1, d, e, rh, rg, rb);
    tests++;
    if (rb !== 0 || d !== 8) begin
      fails++; $display("FAIL busy_ignore: got ready_cycles=%0d done=%0d required 0 8", rb, d);
    end
    tests++;
    if (wr_a_log.size() - w0 !== 2 || wr_a_log[w0] !== 32'hA00 || wr_a_log[w0+1] !== 32'hA04) begin
      fails++; $display("FAIL busy_ignore_writes: got count=%0d required 2 at A00,A04", wr_a_log.size() - w0);
    end
  endtask

  task automatic test_wrap();
    int d, e, rh, rg, rb, r0, w0;
    r0 = rd_log.size(); w0 = wr_a_log.size();
    run_cmd(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd2, 64'd0, 1'b0, d, e, rh, rg, rb);
    tests++;
    if (rd_log.size() - r0 !== 2 || wr_a_log.size() - w0 !== 2) begin
      fails++; $display("FAIL wrap_beats: got rd=%0d wr=%0d required 2 2", rd_log.size() - r0, wr_a_log.size() - w0);
    end else begin
      tests++;
      if (rd_log[r0+1] !== 32'h0 || wr_a_log[w0+1] !== 32'hFFFF_FFFC || wr_d_log[w0+1] !== mem_word(32'h0)) begin
        fails++; $display("FAIL wrap_addr: got rd=%h wr=%h data=%h required 0 fffffffc %h", rd_log[r0+1],
                          wr_a_log[w0+1], wr_d_log[w0+1], mem_word(32'h0));
      end
    end
  endtask

  task automatic test_timeout();
    int d, e, rh, rg, rb, w0;
    w0 = wr_a_log.size();
    // grant withheld in cycles 2..21
    run_cmd(32'h700, 32'h800, 16'd1, 64'h0000_0000_001F_FFFE, 1'b0, d, e, rh, rg, rb);
`ifdef IDS_DMA_TIMEOUT_EN
    tests++;
    if (d !== 16 || e !== 16) begin
      fails++; $display("FAIL timeout_abort: got done=%0d err=%0d required 16 16", d, e);
    end
    tests++;
    if (rh !== 15 || wr_a_log.size() !== w0) begin
      fails++; $display("FAIL timeout_req: got req_cycles=%0d writes=%0d required 15 0", rh, wr_a_log.size() - w0);
    end
`else
    tests++;
    if (d !== 25 || e !== -1) begin
      fails++; $display("FAIL nowait_limit: got done=%0d err=%0d required 25 -1", d, e);
    end
    tests++;
    if (rh !== 24 || rg !== 0 || wr_a_log.size() - w0 !== 1) begin
      fails++; $display("FAIL nowait_req: got req_cycles=%0d gaps=%0d writes=%0d required 24 0 1", rh, rg, wr_a_log.size() - w0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_preempt();
    test_rdwait_drop();
    test_reset_mid();
    test_busy_ignore();
    test_wrap();
    test_timeout();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ids_dma_bus_master.md
# ids_dma_bus_master

Requester-side bus engine for the DMA: accepts a word-copy command, raises `o_req_dma` toward the bus arbiter, and moves data one word at a time (read source, then write destination) only in cycles where `i_gnt_dma` is high. It tolerates grant loss on any cycle, since DMEM always has priority, and resumes without losing or duplicating a beat. It sits between the DMA register block and the shared data bus, opposite the arbiter's DMA grant port.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, bus word width; addresses step by `DATA_W/8`
- `LEN_W`, 16, word-count width
- `TMO_W`, 8, grant-wait timeout counter width (used only with the macro)

Ports:
- `i_clk` in 1: the single clock
- `i_rst` in 1: synchronous, active-high reset
- `i_cmd_valid` in 1: command offered
- `o_cmd_ready` out 1: engine idle; command accepted when both are high
- `i_cmd_src` in ADDR_W: source byte address, word aligned
- `i_cmd_dst` in ADDR_W: destination byte address, word aligned
- `i_cmd_len` in LEN_W: number of words to copy
- `o_busy` out 1: command in progress
- `o_done` out 1: one-cycle completion pulse
- `o_err` out 1: one-cycle abort pulse; constant 0 without the macro
- `o_req_dma` out 1: bus request to the arbiter
- `i_gnt_dma` in 1: bus grant from the arbiter
- `o_bus_valid` out 1: access issued this cycle
- `o_bus_we` out 1: 1 = write, 0 = read
- `o_bus_addr` out ADDR_W: access address
- `o_bus_wdata` out DATA_W: write data
- `i_bus_rdata` in DATA_W: read data, valid exactly one cycle after an issued read

## Operation
- States: `IDLE`, `RD`, `RD_WAIT`, `WR`, `FIN`.
- `IDLE`: `o_cmd_ready`=1.
  - On accept with len=0: go to `FIN`. No request is raised.
  - Otherwise: latch src, dst and len into working registers, then go to `RD`.
- `RD`: `o_req_dma`=1. `o_bus_valid` = `i_gnt_dma`, with `o_bus_we`=0 and `o_bus_addr`=src. A read issues when gnt=1, and the state moves to `RD_WAIT`.
- `RD_WAIT`: `o_req_dma`=1 and `o_bus_valid`=0. Capture `i_bus_rdata` into the data buffer whatever the grant is, then go to `WR`.
- `WR`: `o_req_dma`=1. `o_bus_valid` = `i_gnt_dma`, with `o_bus_we`=1, `o_bus_addr`=dst and `o_bus_wdata`=buffer. When a write issues:
  - src += DATA_W/8, dst += DATA_W/8, len -= 1.
  - If the new len is 0, go to `FIN`; otherwise go to `RD`.
- `FIN`: `o_done`=1 for one cycle and `o_req_dma`=0, then return to `IDLE`.
- `o_busy` = (state ≠ `IDLE`).
- `o_bus_valid` is never high while `i_gnt_dma`=0.
- Grant loss in `RD` or `WR` stalls the state with address and data held; the beat is reissued when the grant returns.
- Address arithmetic wraps modulo 2^ADDR_W. There is no error on wrap.
- `i_cmd_valid` while busy is ignored: ready stays 0 and nothing is latched.
- A grant seen while `o_req_dma`=0 is ignored.

## Timing
- Reset values: state `IDLE`, all counters and registers 0. `o_cmd_ready`=1; `o_busy`, `o_done`, `o_err`, `o_req_dma`, `o_bus_valid` and `o_bus_we` are 0; `o_bus_addr` and `o_bus_wdata` are 0.
- Reset mid-transfer returns to `IDLE` on the next edge. `o_req_dma` drops in that same cycle, and the remaining words are abandoned.
- The arbiter grant is registered, so the first access comes no earlier than 1 cycle after `o_req_dma` rises.
- Uncontended copy of N words: accept at cycle 0, `o_done` at cycle 3N+2.
  - Per word: RD, RD_WAIT, WR.
  - Plus 1 cycle of grant latency at the start and the FIN cycle.
- `o_req_dma` is held continuously from the cycle after accept through the last `WR`. It is not dropped between words.
- All bus outputs are combinational from state, registers and `i_gnt_dma`. No other input-to-output path exists.

## Configuration
- `IDS_DMA_TIMEOUT_EN` defined:
  - A counter runs in `RD` or `WR` while `i_gnt_dma`=0, and clears on any cycle with gnt=1.
  - When it reaches 2^TMO_W−1, the engine aborts: go to `FIN`, drop `o_req_dma`, pulse `o_err` together with `o_done`, and discard the remaining len.
- Undefined: the counter is not built, `o_err` is tied to 0, and the engine waits for the grant indefinitely.

## Structure
- Shared package `ids_dma_pkg`:
  - state enum `dma_mst_state_t`
  - `DMA_WORD_BYTES` constant
  - default widths
- Optional sub-module `ids_dma_gnt_watchdog`: the timeout counter with en, clear and expire ports. Instantiated only under `IDS_DMA_TIMEOUT_EN`.

## Test plan
- **Basic copy:** src=0x100, dst=0x200, len=3, gnt follows req after 1 cycle.
  - Reads at 0x100/104/108 and writes at 0x200/204/208 with matching data.
  - `o_done` at cycle 11.
- **len=0:** accepted, `o_done` on the next cycle, `o_req_dma` never asserted.
- **Preemption:** drop gnt for 5 cycles in `WR` of word 1.
  - `o_bus_valid`=0 throughout the drop.
  - Write of 0x204 issued exactly once after the grant returns; `o_req_dma` stays high.
- **Grant drop during `RD_WAIT`:** read data is still captured and written correctly.
- **Reset mid-transfer:** `i_rst` after the first write of len=4.
  - Next cycle: `o_req_dma`=0, `o_busy`=0, `o_cmd_ready`=1.
  - A new command then runs normally.
- **Timeout (macro on, TMO_W=4):** gnt held 0.
  - After 15 waiting cycles: `o_err` and `o_done` pulse together and `o_req_dma` drops.
  - With the macro off, `o_err` stays 0.
